wb_bus_guard: RTL and testbench

- Wishbone bus watchdog placed between the user_project_wrapper Wishbone port (master side) and the wb_bus address splitter (slave side).
- Forwards every transaction unchanged while it counts wait cycles. If no slave acks within TIMEOUT cycles (unmapped address or hung peripheral), it terminates the cycle itself: it acks the master with ERR_DATA, records the faulting address and raises an interrupt.
- Exposes a two-word CSR window for status and clearing.

---
 rtl/wb_bus_guard.sv | 174 +++++++++++++++++
 tb/tb_wb_bus_guard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_guard.sv
// Wishbone bus watchdog: forwards master cycles to the address splitter, terminates any
// cycle that waits TIMEOUT cycles without a slave ack, logs the fault and raises irq.
// A two-word CSR window (STATUS, FAULT_ADR) is answered locally and never reaches a slave.
module wb_bus_guard #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
    parameter logic [31:0] CSR_BASE = 32'h300F_0000
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] m_adr,
    input  logic [31:0] m_dat_i,
    output logic [31:0] m_dat_o,
    input  logic [3:0]  m_sel,
    input  logic        m_we,
    input  logic        m_stb,
    input  logic        m_cyc,
    output logic        m_ack,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic        s_stb,
    output logic        s_cyc,
    input  logic        s_ack,
    output logic        irq
);

    typedef enum logic [2:0] {StIdle, StFwd, StToAck, StCsrAck, StHold} state_e;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_fault;
    logic             r_fault_we;
    logic [7:0]       r_fault_cnt;
    logic [31:0]      r_fault_adr;

    logic             w_req;
    logic             w_csr_hit;
    logic             w_ack;
    logic [31:0]      w_dat;
    logic             w_fwd_en;
    logic             w_fault_set;
    logic             w_csr_clr;
    logic [31:0]      w_status;
    logic [31:0]      w_csr_rdata;

    assign w_req     = m_cyc & m_stb;
    assign w_csr_hit = w_req & (m_adr[31:3] == CSR_BASE[31:3]);

    assign w_status    = {16'h0000, r_fault_cnt, 6'b000000, r_fault_we, r_fault};
    assign w_csr_rdata = m_adr[2] ? r_fault_adr : w_status;
    // STATUS is W1C on byte lane 0; FAULT_ADR ignores writes.
    assign w_csr_clr   = (r_state == StCsrAck) & m_we & ~m_adr[2] & m_sel[0];

    // Address, data, selects and direction pass straight through.
    assign s_adr   = m_adr;
    assign s_dat_o = m_dat_i;
    assign s_sel   = m_sel;
    assign s_we    = m_we;

    // Reset gates the combinational outputs so they drop without a clock edge.
    assign s_stb   = m_stb & w_fwd_en & ~w_csr_hit & ~wb_rst;
    assign s_cyc   = m_cyc & w_fwd_en & ~w_csr_hit & ~wb_rst;
    assign m_ack   = w_ack & ~wb_rst;
    assign m_dat_o = wb_rst ? 32'h0 : w_dat;
    assign irq     = r_fault;

    // Next-state, wait counter and master-side response.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ack       = 1'b0;
        w_dat       = 32'h0;
        w_fwd_en    = 1'b0;
        w_fault_set = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_fwd_en = 1'b1;
                if (w_csr_hit) begin
                    w_state_nxt = StCsrAck;
                end else if (w_req) begin
                    if (s_ack) begin
                        w_ack = 1'b1;
                        w_dat = s_dat_i;
                    end else begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = StFwd;
                    end
                end
            end
            StFwd: begin
                w_fwd_en = 1'b1;
                w_ack    = s_ack;
                w_dat    = s_dat_i;
                // A slave ack on the last counted cycle still wins over the timeout.
                if (s_ack || !w_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StToAck;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StToAck: begin
                w_ack       = 1'b1;
                w_dat       = ERR_DATA;
                w_fault_set = 1'b1;
                w_state_nxt = StHold;
            end
            StCsrAck: begin
                w_ack       = 1'b1;
                w_dat       = m_we ? 32'h0 : w_csr_rdata;
                w_state_nxt = StHold;
            end
            StHold: begin
                // Wait for the master to release so it never sees a second ack.
                if (!w_req) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Fault log: set on forced termination, cleared by STATUS W1C writes.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_fault     <= 1'b0;
            r_fault_we  <= 1'b0;
            r_fault_cnt <= 8'h00;
            r_fault_adr <= 32'h0;
        end else if (w_fault_set) begin
            r_fault     <= 1'b1;
            r_fault_we  <= m_we;
            r_fault_adr <= m_adr;
            if (r_fault_cnt != 8'hFF) begin
                r_fault_cnt <= r_fault_cnt + 8'h01;
            end
        end else if (w_csr_clr) begin
            if (m_dat_i[0]) begin
                r_fault    <= 1'b0;
                r_fault_we <= 1'b0;
            end
            if (m_dat_i[1]) begin
                r_fault_cnt <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_guard.sv
// Self-checking bench for wb_bus_guard: directed master transactions, a scripted slave,
// and a scoreboard monitor that checks read data on every master ack.
module tb_wb_bus_guard;

    localparam logic [31:0] STATUS_A = 32'h300F_0000;
    localparam logic [31:0] FADR_A   = 32'h300F_0004;
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] m_adr;
    logic [31:0] m_dat_i;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        m_stb;
    logic        m_cyc;
    logic        m_ack;
    logic [31:0] s_adr;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic [3:0]  s_sel;
    logic        s_we;
    logic        s_stb;
    logic        s_cyc;
    logic        s_ack;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int          slv_dly = -1;
    logic [31:0] exp_q[$];

    wb_bus_guard #(
        .TIMEOUT (16),
        .CNT_W   (8),
        .ERR_DATA(32'hDEAD_BEEF),
        .CSR_BASE(32'h300F_0000)
    ) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .m_adr  (m_adr),
        .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o),
        .m_sel  (m_sel),
        .m_we   (m_we),
        .m_stb  (m_stb),
        .m_cyc  (m_cyc),
        .m_ack  (m_ack),
        .s_adr  (s_adr),
        .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),
        .s_sel  (s_sel),
        .s_we   (s_we),
        .s_stb  (s_stb),
        .s_cyc  (s_cyc),
        .s_ack  (s_ack),
        .irq    (irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every master ack must match the next queued response.
    always @(negedge wb_clk) begin
        if (m_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack data %h expected no ack", m_dat_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_dat_o !== e) begin
                    errors++;
                    $display("FAIL ack_data: got %h expected %h", m_dat_o, e);
                end
            end
        end
    end

    // Scripted slave: with stb seen in cycles 1..k, acks in cycle slv_dly+1 (never if < 0).
    initial begin
        int  scnt;
        logic nxt;
        scnt  = 0;
        s_ack = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (s_stb && s_cyc && !s_ack) begin
                scnt++;
                nxt = (slv_dly >= 0) && (scnt == slv_dly);
            end else begin
                scnt = 0;
                nxt  = 1'b0;
            end
            @(posedge wb_clk);
            #1;
            s_ack = nxt;
        end
    end

    // One master transaction, started 1 time unit after a rising edge.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int dly, input logic [31:0] exp,
                        input int hold, output int lat, output int stb_cnt);
        bit got;
        slv_dly = dly;
        exp_q.push_back(exp);
        m_adr   = adr;
        m_we    = we;
        m_dat_i = wdat;
        m_sel   = sel;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        lat     = 1;
        stb_cnt = 0;
        got     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk);
            if (s_stb) stb_cnt++;
            if (m_ack) begin
                got = 1'b1;
                break;
            end
            @(posedge wb_clk);
            #1;
            lat++;
        end
        if (!got) begin
            chk("ack_timeout", 32'(got), 32'd1);
            void'(exp_q.pop_back());
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge wb_clk);
            #1;
            @(negedge wb_clk);
            if (s_stb) stb_cnt++;
        end
        @(posedge wb_clk);
        #1;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
        @(posedge wb_clk);
        #1;
    endtask

    initial begin
        int lat;
        int sc;
        int nbad;
        wb_rst  = 1'b1;
        m_adr   = 32'h0;
        m_dat_i = 32'h0;
        m_sel   = 4'h0;
        m_we    = 1'b0;
        m_stb   = 1'b0;
        m_cyc   = 1'b0;
        s_dat_i = 32'h1234_5678;

        // Reset state
        @(negedge wb_clk);
        chk("rst_m_ack", 32'(m_ack), 32'd0);
        chk("rst_s_stb", 32'(s_stb), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_m_dat_o", m_dat_o, 32'h0);
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;

        // Mapped read, slave acks in cycle 3
        xfer(32'h3002_0000, 1'b0, 32'h0, 4'hF, 2, 32'h1234_5678, 0, lat, sc);
        chk("mapped_lat", 32'(lat), 32'd3);
        chk("mapped_stb_cycles", 32'(sc), 32'd3);
        chk("mapped_irq", 32'(irq), 32'd0);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0, 0, lat, sc);

        // Unmapped read times out
        xfer(32'h3005_0000, 1'b0, 32'h0, 4'hF, -1, DEADBEEF, 0, lat, sc);
        chk("to_lat", 32'(lat), 32'd17);
        chk("to_stb_cycles", 32'(sc), 32'd16);
        chk("to_irq", 32'(irq), 32'd1);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0000_0101, 0, lat, sc);
        chk("csr_rd_lat", 32'(lat), 32'd2);
        xfer(FADR_A, 1'b0, 32'h0, 4'hF, -1, 32'h3005_0000, 0, lat, sc);

        // Race: slave ack in cycle 16 beats the timeout
        s_dat_i = 32'hA5A5_0016;
        xfer(32'h3005_0004, 1'b0, 32'h0, 4'hF, 15, 32'hA5A5_0016, 0, lat, sc);
        chk("race_lat", 32'(lat), 32'd16);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0000_0101, 0, lat, sc);

        // CSR clears: W1C of FAULT then FAULT_CNT, never forwarded
        xfer(STATUS_A, 1'b1, 32'h1, 4'h1, -1, 32'h0, 0, lat, sc);
        chk("clr1_lat", 32'(lat), 32'd2);
        chk("clr1_stb_cycles", 32'(sc), 32'd0);
        chk("clr1_irq", 32'(irq), 32'd0);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0000_0100, 0, lat, sc);
        xfer(STATUS_A, 1'b1, 32'h2, 4'h1, -1, 32'h0, 0, lat, sc);
        chk("clr2_stb_cycles", 32'(sc), 32'd0);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0, 0, lat, sc);
        // FAULT_ADR is read-only
        xfer(FADR_A, 1'b1, 32'h1234_5678, 4'hF, -1, 32'h0, 0, lat, sc);
        xfer(FADR_A, 1'b0, 32'h0, 4'hF, -1, 32'h3005_0000, 0, lat, sc);

        // Saturation with master holding stb after each ack
        nbad = 0;
        for (int i = 0; i < 300; i++) begin
            xfer(32'h3006_0000, 1'b1, 32'(i), 4'hF, -1, DEADBEEF, 5, lat, sc);
            if (lat != 17 || sc != 16) nbad++;
        end
        chk("sat_bad_xfers", 32'(nbad), 32'd0);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0000_FF03, 0, lat, sc);
        xfer(FADR_A, 1'b0, 32'h0, 4'hF, -1, 32'h3006_0000, 0, lat, sc);
        // Clear write without byte lane 0 has no effect
        xfer(STATUS_A, 1'b1, 32'h3, 4'hE, -1, 32'h0, 0, lat, sc);
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0000_FF03, 0, lat, sc);
        chk("pre_rst_irq", 32'(irq), 32'd1);

        // Async reset pulse in FWD cycle 8
        slv_dly = -1;
        m_adr   = 32'h3002_0000;
        m_we    = 1'b0;
        m_sel   = 4'hF;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
        repeat (7) begin
            @(posedge wb_clk);
            #1;
        end
        #2;
        wb_rst = 1'b1;
        #1;
        chk("arst_m_ack", 32'(m_ack), 32'd0);
        chk("arst_s_stb", 32'(s_stb), 32'd0);
        chk("arst_s_cyc", 32'(s_cyc), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_m_dat_o", m_dat_o, 32'h0);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;
        xfer(STATUS_A, 1'b0, 32'h0, 4'hF, -1, 32'h0, 0, lat, sc);
        xfer(FADR_A, 1'b0, 32'h0, 4'hF, -1, 32'h0, 0, lat, sc);
        s_dat_i = 32'h0BAD_F00D;
        xfer(32'h3002_0000, 1'b0, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 0, lat, sc);
        chk("post_rst_lat", 32'(lat), 32'd3);

        repeat (3) @(posedge wb_clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
